rsa_exp_ctrl: RTL and testbench
===============================

// Module: rsa_exp_ctrl
// PURPOSE
//   Controller for RSA modular exponentiation, result = M^e mod N (LSB-first square-and-multiply).
//   Sequences one pre_processing unit (T0 = M*2^W mod N) and one shared Montgomery multiplier
//   (MM(a,b) = a*b*2^-W mod N) through start/ready handshakes.
//   Owns the S (result) and T (power) operand registers.
//   Sits between the top-level I/O wrapper and the two arithmetic datapaths.
// PARAMETERS
//   WIDTH  256  operand/modulus width in bits
//   CNT_W  9    bit-counter width; must satisfy 2^CNT_W > WIDTH
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   start      in   1        one-cycle request; sampled only in IDLE
//   e          in   WIDTH    exponent; captured on accepted start
//   pp_start   out  1        one-cycle start pulse to pre_processing
//   pp_ready   in   1        pre_processing done (level)
//   pp_V       in   WIDTH+1  pre_processing result; low WIDTH bits used (V < N)
//   mm_start   out  1        one-cycle start pulse to the Montgomery multiplier
//   mm_a       out  WIDTH    multiplier operand A; stable from mm_start until capture
//   mm_b       out  WIDTH    multiplier operand B; stable from mm_start until capture
//   mm_ready   in   1        multiplier done (level)
//   mm_result  in   WIDTH    multiplier result
//   busy       out  1        high in every state except IDLE
//   done       out  1        one-cycle pulse when result is valid
//   result     out  WIDTH    M^e mod N; held until the next accepted start
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE; S, T, result, exponent register, counter = 0.
//   - pp_start, mm_start, busy, done = 0.
//   - Applies in any state; an in-flight operation is abandoned with no done pulse.
// - FSM states: IDLE, PP_GO, PP_WAIT, BIT, MUL_GO, MUL_WAIT, SQR_GO, SQR_WAIT, NEXT, FIN.
// - IDLE:
//   - start=1 -> capture e into E, S<=1, cnt<=0, go to PP_GO.
//   - start while busy is ignored.
// - PP_GO: pp_start=1 for exactly 1 cycle -> PP_WAIT.
// - PP_WAIT:
//   - Guard cycle: pp_ready is ignored in the first cycle after entry (stale-ready protection).
//   - Afterwards, pp_ready=1 -> T <= pp_V[WIDTH-1:0], go to BIT.
// - BIT: E[0]=1 -> MUL_GO; else -> SQR_GO.
// - MUL_GO / MUL_WAIT:
//   - mm_a=S, mm_b=T; mm_start pulses 1 cycle in MUL_GO.
//   - Same 1-cycle ready guard as PP_WAIT.
//   - mm_ready=1 -> S <= mm_result, go to SQR_GO.
// - SQR_GO / SQR_WAIT:
//   - mm_a=T, mm_b=T; mm_start pulses 1 cycle; same guard.
//   - mm_ready=1 -> T <= mm_result, go to NEXT.
// - NEXT:
//   - E <= E>>1.
//   - cnt==WIDTH-1 -> FIN; else cnt<=cnt+1 -> BIT.
//   - All WIDTH bits are always processed, including when the upper bits of e are zero.
// - FIN: result <= S, done=1 for 1 cycle -> IDLE (busy=0 next cycle).
// - Operand selection:
//   - mm_a/mm_b are registered-state decoded.
//   - In IDLE/PP states they drive 0.
// - Domain:
//   - S starts at plain 1; MM(S,T) with T in the Montgomery domain keeps S in the plain domain.
//   - No post-conversion is needed.
// - Operation counts:
//   - exactly 1 pp_start per operation;
//   - popcount(e) + WIDTH mm_start pulses;
//   - pp_start and mm_start are never high together;
//   - at most one outstanding request.
// - Latency: 2 + Lpp + WIDTH*(2 + Lsq + 1) + popcount(e)*(1 + Lmul) + 1 cycles, where L* = handshake wait.
// - Ready dropping/glitching outside the WAIT states has no effect.
// TESTING (behavioural pp/mm models, fixed latency 5, WIDTH=256)
// 1. M=4, e=13, N=497 -> result=445; done pulses once; mm_start count=259.
// 2. e=0, M=7, N=11 -> result=1; 256 squares, 0 multiplies.
// 3. e=all ones -> 512 mm_start pulses; result matches the golden model; busy high throughout.
// 4. start re-pulsed mid-operation -> ignored; result unchanged versus the uninterrupted run.
// 5. rst_n=0 during MUL_WAIT -> all outputs 0 immediately; new start afterwards gives the correct result.
// 6. models hold ready=1 from a previous op for 1 cycle after start -> guard prevents a false capture.

Source files
------------

// File: rtl/rsa_exp_ctrl.sv
// Square-and-multiply sequencer for M^e mod N. Drives one pre-processing unit and
// one shared Montgomery multiplier, and owns the S (result) and T (power) registers.
module rsa_exp_ctrl #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] e,
  output logic             pp_start,
  input  logic             pp_ready,
  input  logic [WIDTH:0]   pp_V,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  input  logic             mm_ready,
  input  logic [WIDTH-1:0] mm_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // Handshake: a *_start pulse lasts one cycle; the datapath raises *_ready (level)
  // when its result is valid. Operands stay stable until the result is captured.
  // The first WAIT cycle ignores ready, so a level left high by the previous
  // request cannot be captured as the new result.

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] PP_GO    = 4'd1;
  localparam logic [3:0] PP_WAIT  = 4'd2;
  localparam logic [3:0] BIT      = 4'd3;
  localparam logic [3:0] MUL_GO   = 4'd4;
  localparam logic [3:0] MUL_WAIT = 4'd5;
  localparam logic [3:0] SQR_GO   = 4'd6;
  localparam logic [3:0] SQR_WAIT = 4'd7;
  localparam logic [3:0] NEXT     = 4'd8;
  localparam logic [3:0] FIN      = 4'd9;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [3:0]       state;
  logic [WIDTH-1:0] s_reg;
  logic [WIDTH-1:0] t_reg;
  logic [WIDTH-1:0] e_reg;
  logic [CNT_W-1:0] cnt;
  logic             guard;
  logic             unused_pp_msb;

  assign unused_pp_msb = pp_V[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      s_reg  <= '0;
      t_reg  <= '0;
      e_reg  <= '0;
      cnt    <= '0;
      result <= '0;
      guard  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            e_reg <= e;
            s_reg <= WIDTH'(1);
            cnt   <= '0;
            state <= PP_GO;
          end
        end
        PP_GO: begin
          guard <= 1'b1;
          state <= PP_WAIT;
        end
        PP_WAIT: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (pp_ready) begin
            t_reg <= pp_V[WIDTH-1:0];
            state <= BIT;
          end
        end
        BIT: begin
          state <= e_reg[0] ? MUL_GO : SQR_GO;
        end
        MUL_GO: begin
          guard <= 1'b1;
          state <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (mm_ready) begin
            s_reg <= mm_result;
            state <= SQR_GO;
          end
        end
        SQR_GO: begin
          guard <= 1'b1;
          state <= SQR_WAIT;
        end
        SQR_WAIT: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (mm_ready) begin
            t_reg <= mm_result;
            state <= NEXT;
          end
        end
        NEXT: begin
          e_reg <= e_reg >> 1;
          // S is final here, so result is already valid in the FIN (done) cycle.
          if (cnt == LAST_BIT) begin
            result <= s_reg;
            state  <= FIN;
          end else begin
            cnt   <= cnt + CNT_W'(1);
            state <= BIT;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign pp_start = (state == PP_GO);
  assign mm_start = (state == MUL_GO) || (state == SQR_GO);
  assign busy     = (state != IDLE);
  assign done     = (state == FIN);

  always_comb begin
    mm_a = '0;
    mm_b = '0;
    case (state)
      MUL_GO, MUL_WAIT: begin
        mm_a = s_reg;
        mm_b = t_reg;
      end
      SQR_GO, SQR_WAIT: begin
        mm_a = t_reg;
        mm_b = t_reg;
      end
      default: begin
        mm_a = '0;
        mm_b = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Bench for rsa_exp_ctrl: behavioural pre-processing and Montgomery models with
// fixed latency, plus a plain modular-exponentiation reference and cycle budget.
module tb_rsa_exp_ctrl;

  localparam int W   = 256;
  localparam int LAT = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   e;
  logic           pp_start;
  logic           pp_ready = 1'b0;
  logic [W:0]     pp_V = '0;
  logic           mm_start;
  logic [W-1:0]   mm_a;
  logic [W-1:0]   mm_b;
  logic           mm_ready = 1'b0;
  logic [W-1:0]   mm_result = '0;
  logic           busy;
  logic           done;
  logic [W-1:0]   result;

  rsa_exp_ctrl #(.WIDTH(W), .CNT_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .e(e),
    .pp_start(pp_start), .pp_ready(pp_ready), .pp_V(pp_V),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
    .mm_ready(mm_ready), .mm_result(mm_result),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  longint unsigned cur_m = 64'd0;
  longint unsigned cur_n = 64'd3;
  logic [W-1:0] exp_q[$];
  int last_mm = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic longint unsigned mont(input logic [W-1:0] a, input longint unsigned b,
                                           input longint unsigned n);
    longint unsigned t = 64'd0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) t = t + b;
      if (t[0]) t = t + n;
      t = t >> 1;
    end
    if (t >= n) t = t - n;
    return t;
  endfunction

  function automatic longint unsigned to_mont(input longint unsigned m, input longint unsigned n);
    longint unsigned v = m % n;
    for (int i = 0; i < W; i++) v = (v << 1) % n;
    return v;
  endfunction

  function automatic longint unsigned modexp(input longint unsigned m, input logic [W-1:0] ee,
                                             input longint unsigned n);
    longint unsigned r = 64'd1 % n;
    longint unsigned b = m % n;
    for (int i = 0; i < W; i++) begin
      if (ee[i]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return r;
  endfunction

  function automatic int popcnt(input logic [W-1:0] v);
    int c = 0;
    for (int i = 0; i < W; i++) if (v[i]) c++;
    return c;
  endfunction

  function automatic logic [W-1:0] rand_e();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- datapath models (ready stays high into the next guard cycle) -------
  int pp_ph = 0;
  bit pp_act = 1'b0;
  longint unsigned pp_res = 64'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pp_ready = 1'b0;
      pp_act   = 1'b0;
    end else if (pp_act) begin
      pp_ph++;
      if (pp_ph == 2) pp_ready = 1'b0;
      if (pp_ph == LAT) begin
        pp_V     = {1'($urandom_range(0, 1)), W'(pp_res)};
        pp_ready = 1'b1;
        pp_act   = 1'b0;
      end
    end else if (pp_start) begin
      pp_act = 1'b1;
      pp_ph  = 0;
      pp_res = to_mont(cur_m, cur_n);
    end else begin
      pp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  int mm_ph = 0;
  bit mm_act = 1'b0;
  longint unsigned mm_res = 64'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mm_ready = 1'b0;
      mm_act   = 1'b0;
    end else if (mm_act) begin
      mm_ph++;
      if (mm_ph == 2) mm_ready = 1'b0;
      if (mm_ph == LAT) begin
        mm_result = W'(mm_res);
        mm_ready  = 1'b1;
        mm_act    = 1'b0;
      end
    end else if (mm_start) begin
      mm_act = 1'b1;
      mm_ph  = 0;
      mm_res = mont(mm_a, mm_b[63:0], cur_n);
    end else begin
      mm_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- compare process ----------------
  bit           active = 1'b0;
  int           cyc = 0;
  int           exp_lat = 0;
  int           exp_pop = 0;
  int           n_pp = 0;
  int           n_mm = 0;
  logic [W-1:0] held_result = '0;
  logic [W-1:0] exp_res;

  always @(negedge clk) begin
    if (!rst_n) begin
      active      = 1'b0;
      held_result = '0;
      exp_q.delete();
    end else begin
      check("start_overlap", W'(pp_start & mm_start), W'(0));
      if (!active) begin
        check("idle_outputs", W'({busy, done, pp_start, mm_start}), W'(0));
        check("idle_operands", mm_a | mm_b, W'(0));
        if (start) begin
          check("result_hold", result, held_result);
          active  = 1'b1;
          cyc     = 0;
          exp_pop = popcnt(e);
          exp_lat = 2 + LAT + W * (3 + LAT) + exp_pop * (1 + LAT) + 1;
          n_pp    = 0;
          n_mm    = 0;
        end
      end else begin
        cyc++;
        if (pp_start) n_pp++;
        if (mm_start) n_mm++;
        check("busy", W'(busy), W'(1));
        check("done", W'(done), W'(cyc == exp_lat - 1));
        if (cyc == exp_lat - 1) begin
          if (exp_q.size() == 0) begin
            check("exp_queue_empty", W'(1), W'(0));
            exp_res = '0;
          end else begin
            exp_res = exp_q.pop_front();
          end
          check("result", result, exp_res);
          check("pp_start_count", W'(n_pp), W'(1));
          check("mm_start_count", W'(n_mm), W'(W + exp_pop));
          held_result = exp_res;
          last_mm     = n_mm;
          active      = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input longint unsigned m, input logic [W-1:0] ee, input longint unsigned n);
    @(posedge clk);
    #1;
    cur_m = m;
    cur_n = n;
    e     = ee;
    start = 1'b1;
    exp_q.push_back(W'(modexp(m, ee, n)));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic stray_start(input logic [W-1:0] ee);
    @(posedge clk);
    #1;
    e     = ee;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    if (!got) check({name, "_timeout"}, W'(0), W'(1));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, W'({busy, done, pp_start, mm_start}), W'(0));
    check({name, "_result"}, result, W'(0));
    check({name, "_operands"}, mm_a | mm_b, W'(0));
  endtask

  function automatic longint unsigned rand_n();
    return 64'($urandom_range(32'h7fff_ffff, 32'd3) | 32'd1);
  endfunction

  // ---------------- stimulus ----------------
  longint unsigned rn;
  logic [W-1:0]    re;
  bit              seen;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    e     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // M=4, e=13, N=497: 4^13 mod 497 = 445, popcount 3 -> 259 multiplier starts
    start_op(64'd4, W'(13), 64'd497);
    wait_done("t1");
    check("t1_result_literal", result, W'(445));
    check("t1_mm_literal", W'(last_mm), W'(259));

    // e=0 -> 1, squares only
    start_op(64'd7, W'(0), 64'd11);
    wait_done("t2");
    check("t2_result_literal", result, W'(1));
    check("t2_mm_literal", W'(last_mm), W'(256));

    // all-ones exponent
    rn = rand_n();
    start_op(64'($urandom) % rn, '1, rn);
    wait_done("t3");
    check("t3_mm_literal", W'(last_mm), W'(512));

    // stray start pulses while busy
    rn = rand_n();
    start_op(64'($urandom) % rn, rand_e(), rn);
    repeat ($urandom_range(10, 1500)) @(posedge clk);
    stray_start(rand_e());
    repeat ($urandom_range(10, 300)) @(posedge clk);
    stray_start(rand_e());
    wait_done("t4");

    // reset during the first multiply wait
    rn = rand_n();
    re = rand_e();
    re[0] = 1'b1;
    start_op(64'($urandom) % rn, re, rn);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mm_start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("t5_mm_start_timeout", W'(0), W'(1));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rn = rand_n();
    start_op(64'($urandom) % rn, rand_e(), rn);
    wait_done("t5_after");

    // random operations
    for (int k = 0; k < 3; k++) begin
      rn = rand_n();
      start_op(64'($urandom) % rn, rand_e(), rn);
      wait_done("rand");
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
